// File: rtl/fir_coef_pkg.sv
// fir_coef_pkg
// Shared definitions for the FIR coefficient controller: register map
// indices, control-word bit positions, write-channel FSM states and the
// pass-through kernel loaded at reset.

package fir_coef_pkg;

    // Word indices decoded from awaddr[7:2]
    localparam logic [5:0] REG_TAP0  = 6'd0;
    localparam logic [5:0] REG_SHIFT = 6'd9;
    localparam logic [5:0] REG_CTRL  = 6'd10;

    // Control register bit positions
    localparam int CTRL_ARM     = 0;
    localparam int CTRL_NOW     = 1;
    localparam int CTRL_CLR_ERR = 2;

    typedef enum logic [1:0] {
        WR_IDLE      = 2'd0,
        WR_HAVE_ADDR = 2'd1,
        WR_HAVE_DATA = 2'd2,
        WR_WRITE     = 2'd3
    } wr_state_e;

    // Reset kernel: unity centre tap, every other tap zero, no shift
    localparam int RST_CENTER_TAP  = 4;
    localparam int RST_CENTER_COEF = 1;
    localparam int RST_SHIFT       = 0;

endpackage

// File: rtl/fir_coef_axi_wr.sv
// fir_coef_axi_wr
// AXI4-Lite-style write address/data acceptor. Captures the word index and
// data of one write, then presents them for exactly one cycle on
// wr_en/wr_idx/wr_data.
//
// Ports:
//   clk, rst_n            pixel clock, async active-low reset
//   awaddr/awvalid/awready write address channel (only bits [7:2] kept)
//   wdata/wvalid/wready   write data channel
//   wr_en                 one-cycle strobe, captured write is applied
//   wr_idx, wr_data       captured word index and data
//
// state        | meaning
// WR_IDLE      | both channels open, waiting for address and/or data
// WR_HAVE_ADDR | address captured, waiting for data
// WR_HAVE_DATA | data captured, waiting for address
// WR_WRITE     | both captured, strobe wr_en for one cycle

module fir_coef_axi_wr
    import fir_coef_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic              wr_en,
    output logic [5:0]        wr_idx,
    output logic [31:0]       wr_data
);

    wr_state_e   state, state_nx;
    logic        rdy_en;
    logic        aw_hs;
    logic        w_hs;
    logic [5:0]  idx_q;
    logic [31:0] data_q;

    logic unused_addr;
    assign unused_addr = ^{awaddr[ADDR_W-1:8], awaddr[1:0]};

    // Readies stay low during the cycle in which reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= WR_IDLE;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_nx;
            rdy_en <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        awready  = 1'b0;
        wready   = 1'b0;
        wr_en    = 1'b0;
        case (state)
            WR_IDLE: begin
                awready = rdy_en;
                wready  = rdy_en;
                if (awvalid && rdy_en && wvalid)
                    state_nx = WR_WRITE;
                else if (awvalid && rdy_en)
                    state_nx = WR_HAVE_ADDR;
                else if (wvalid && rdy_en)
                    state_nx = WR_HAVE_DATA;
            end
            WR_HAVE_ADDR: begin
                wready = 1'b1;
                if (wvalid)
                    state_nx = WR_WRITE;
            end
            WR_HAVE_DATA: begin
                awready = 1'b1;
                if (awvalid)
                    state_nx = WR_WRITE;
            end
            WR_WRITE: begin
                wr_en    = 1'b1;
                state_nx = WR_IDLE;
            end
            default: state_nx = WR_IDLE;
        endcase
    end

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            if (aw_hs)
                idx_q <= awaddr[7:2];
            if (w_hs)
                data_q <= wdata;
        end
    end

    assign wr_idx  = idx_q;
    assign wr_data = data_q;

endmodule

// File: rtl/fir_coef_ctrl.sv
// fir_coef_ctrl
// Coefficient controller for the 3x3 FIR filter. Bus writes land in a
// shadow bank; the active bank driving the filter is refreshed from the
// shadow only on a commit, either armed for the next vertical-sync rise or
// requested immediately, so the kernel never changes mid-frame.
//
// Ports:
//   clk, rst_n            pixel clock, async active-low reset
//   awaddr..wready        AXI4-Lite-style write address/data channels
//   vs_i                  vertical sync from the video path
//   coef_o                active kernel, tap k at [k*COEF_W +: COEF_W]
//   shift_o               active normalisation shift
//   pending_o             commit armed, waiting for vs rise
//   commit_o              one-cycle pulse after the active bank updates
//   err_o                 sticky, set by a write to an unmapped index

module fir_coef_ctrl
    import fir_coef_pkg::*;
#(
    parameter int NTAPS   = 9,
    parameter int COEF_W  = 8,
    parameter int SHIFT_W = 4,
    parameter int ADDR_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_W-1:0]       awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [31:0]             wdata,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic                    vs_i,
    output logic [NTAPS*COEF_W-1:0] coef_o,
    output logic [SHIFT_W-1:0]      shift_o,
    output logic                    pending_o,
    output logic                    commit_o,
    output logic                    err_o
);

    logic              wr_en;
    logic [5:0]        wr_idx;
    logic [31:0]       wr_data;

    logic [COEF_W-1:0] shad_coef [NTAPS];
    logic [COEF_W-1:0] act_coef  [NTAPS];
    logic [SHIFT_W-1:0] shad_shift;
    logic [SHIFT_W-1:0] act_shift;

    logic [NTAPS-1:0]  tap_we;
    logic              shift_we;
    logic              ctrl_we;
    logic              bad_we;
    logic              arm_wr;
    logic              now_wr;
    logic              clr_wr;
    logic              vs_q;
    logic              vs_rise;
    logic              edge_commit;
    logic              do_commit;
    logic              pending_q;
    logic              commit_q;
    logic              err_q;

    logic unused_wdata;
    assign unused_wdata = ^wr_data[31:COEF_W];

    fir_coef_axi_wr #(
        .ADDR_W (ADDR_W)
    ) u_axi_wr (
        .clk     (clk),
        .rst_n   (rst_n),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wvalid  (wvalid),
        .wready  (wready),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data)
    );

    always_comb begin
        tap_we = '0;
        for (int k = 0; k < NTAPS; k++)
            tap_we[k] = wr_en && (wr_idx == REG_TAP0 + 6'(k));
        shift_we = wr_en && (wr_idx == REG_SHIFT);
        ctrl_we  = wr_en && (wr_idx == REG_CTRL);
        bad_we   = wr_en && !(|tap_we) && !shift_we && !ctrl_we;
    end

    assign arm_wr  = ctrl_we && wr_data[CTRL_ARM];
    assign now_wr  = ctrl_we && wr_data[CTRL_NOW];
    assign clr_wr  = ctrl_we && wr_data[CTRL_CLR_ERR];
    assign vs_rise = vs_i && !vs_q;

    // An arm landing on the vs-rise cycle defers the commit to the next
    // frame rather than committing on this edge.
    assign edge_commit = vs_rise && pending_q && !arm_wr;
    assign do_commit   = now_wr || edge_commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q      <= 1'b0;
            pending_q <= 1'b0;
            commit_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            vs_q     <= vs_i;
            commit_q <= do_commit;
            if (now_wr)
                pending_q <= 1'b0;
            else if (arm_wr)
                pending_q <= 1'b1;
            else if (edge_commit)
                pending_q <= 1'b0;
            if (clr_wr)
                err_q <= 1'b0;
            else if (bad_we)
                err_q <= 1'b1;
        end
    end

    // A commit copies the shadow as it stands before any same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                shad_coef[k] <= (k == RST_CENTER_TAP) ? COEF_W'(RST_CENTER_COEF) : COEF_W'(0);
                act_coef[k]  <= (k == RST_CENTER_TAP) ? COEF_W'(RST_CENTER_COEF) : COEF_W'(0);
            end
            shad_shift <= SHIFT_W'(RST_SHIFT);
            act_shift  <= SHIFT_W'(RST_SHIFT);
        end else begin
            for (int k = 0; k < NTAPS; k++) begin
                if (tap_we[k])
                    shad_coef[k] <= wr_data[COEF_W-1:0];
                if (do_commit)
                    act_coef[k] <= shad_coef[k];
            end
            if (shift_we)
                shad_shift <= wr_data[SHIFT_W-1:0];
            if (do_commit)
                act_shift <= shad_shift;
        end
    end

    for (genvar g = 0; g < NTAPS; g++) begin : g_coef
        assign coef_o[g*COEF_W +: COEF_W] = act_coef[g];
    end

    assign shift_o   = act_shift;
    assign pending_o = pending_q;
    assign commit_o  = commit_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
module tb_fir_coef_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic        vs_i;
    logic [71:0] coef_o;
    logic [3:0]  shift_o;
    logic        pending_o;
    logic        commit_o;
    logic        err_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    fir_coef_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wvalid    (wvalid),
        .wready    (wready),
        .vs_i      (vs_i),
        .coef_o    (coef_o),
        .shift_o   (shift_o),
        .pending_o (pending_o),
        .commit_o  (commit_o),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register-level rules of the controller.
    logic [7:0]  m_shad [9];
    logic [7:0]  m_act  [9];
    logic [3:0]  m_shad_sh;
    logic [3:0]  m_act_sh;
    bit          m_pend, m_commit, m_err, m_vsq, m_rdy;
    bit          m_ah, m_wh, m_wr;
    logic [5:0]  m_idx;
    logic [31:0] m_data;
    bit          m_last_aacc, m_last_wacc;
    bit          chk_en = 1'b0;

    task automatic model_reset();
        for (int k = 0; k < 9; k++) begin
            m_shad[k] = (k == 4) ? 8'd1 : 8'd0;
            m_act[k]  = (k == 4) ? 8'd1 : 8'd0;
        end
        m_shad_sh = 4'd0;
        m_act_sh  = 4'd0;
        m_pend = 0; m_commit = 0; m_err = 0; m_vsq = 0; m_rdy = 0;
        m_ah = 0; m_wh = 0; m_wr = 0;
        m_idx = '0; m_data = '0;
        m_last_aacc = 0; m_last_wacc = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin : mdl
        logic [7:0] old_shad [9];
        logic [3:0] old_sh;
        bit ea, ew, aacc, wacc, arm, now_b, clr, bad, edge_c, wr_next;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int k = 0; k < 9; k++) old_shad[k] = m_shad[k];
            old_sh = m_shad_sh;
            ea = m_rdy && !m_ah && !m_wr;
            ew = m_rdy && !m_wh && !m_wr;
            aacc = awvalid && ea;
            wacc = wvalid && ew;
            arm = 0; now_b = 0; clr = 0; bad = 0;
            if (m_wr) begin
                if (m_idx < 6'd9)       m_shad[m_idx] = m_data[7:0];
                else if (m_idx == 6'd9) m_shad_sh = m_data[3:0];
                else if (m_idx == 6'd10) begin
                    arm = m_data[0]; now_b = m_data[1]; clr = m_data[2];
                end else bad = 1;
            end
            edge_c = vs_i && !m_vsq && m_pend && !arm;
            if (now_b || edge_c) begin
                for (int k = 0; k < 9; k++) m_act[k] = old_shad[k];
                m_act_sh = old_sh;
            end
            if (now_b)       m_pend = 0;
            else if (arm)    m_pend = 1;
            else if (edge_c) m_pend = 0;
            m_commit = now_b || edge_c;
            if (clr)      m_err = 0;
            else if (bad) m_err = 1;
            wr_next = 0;
            if (aacc) begin m_ah = 1; m_idx = awaddr[7:2]; end
            if (wacc) begin m_wh = 1; m_data = wdata; end
            if (m_ah && m_wh) begin wr_next = 1; m_ah = 0; m_wh = 0; end
            m_wr = wr_next;
            m_vsq = vs_i;
            m_rdy = 1;
            m_last_aacc = aacc;
            m_last_wacc = wacc;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [71:0] exp_coef;
        if (chk_en) begin
            for (int k = 0; k < 9; k++) exp_coef[k*8 +: 8] = m_act[k];
            check("awready", awready, m_rdy && !m_ah && !m_wr);
            check("wready",  wready,  m_rdy && !m_wh && !m_wr);
            check("coef",    coef_o,  exp_coef);
            check("shift",   shift_o, m_act_sh);
            check("pending", pending_o, m_pend);
            check("commit",  commit_o,  m_commit);
            check("err",     err_o,     m_err);
        end
    end

    // Called at a negedge; returns at the negedge of the WRITE cycle.
    task automatic do_write(input logic [5:0] idx, input logic [31:0] data,
                            input int da, input int dw, input bit vs_at_wr);
        bit ad = 0, wd = 0;
        logic [31:0] addr;
        addr = $urandom;
        addr[7:2] = idx;
        if (vs_at_wr) vs_i = 1'b0;
        for (int t = 0; t < 30 && !(ad && wd); t++) begin
            awvalid = !ad && (t >= da);
            awaddr  = awvalid ? addr : 32'($urandom);
            wvalid  = !wd && (t >= dw);
            wdata   = wvalid ? data : 32'($urandom);
            @(negedge clk);
            if (m_last_aacc) ad = 1;
            if (m_last_wacc) wd = 1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("hs_done", {ad, wd}, 2'b11);
        if (vs_at_wr) vs_i = 1'b1;
    endtask

    task automatic idle(input int n, input bit rnd_vs);
        repeat (n) begin
            @(negedge clk);
            if (rnd_vs && ($urandom_range(0, 3) == 0)) vs_i = ~vs_i;
        end
    endtask

    task automatic vs_pulse();
        @(negedge clk); vs_i = 1'b1;
        @(negedge clk);
        @(negedge clk); vs_i = 1'b0;
        idle(3, 0);
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; vs_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  idx;
        logic [31:0] data;
        int r;
        rst_n = 1'b1; awvalid = 0; wvalid = 0; awaddr = '0; wdata = '0; vs_i = 0;
        model_reset();
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(3, 0);

        // Load all-ones kernel, shift 3, arm; commit on vs rise
        for (int k = 0; k < 9; k++) do_write(6'(k), 32'd1, 0, 0, 0);
        do_write(6'd9, 32'd3, 0, 0, 0);
        do_write(6'd10, 32'h1, 0, 0, 0);
        idle(4, 0);
        vs_pulse();

        // Skewed channels
        do_write(6'd2, 32'h7f, 3, 0, 0);
        do_write(6'd3, 32'h80, 0, 3, 0);
        idle(2, 0);

        // Arm landing on the vs-rise cycle: no commit until next frame
        do_write(6'd10, 32'h1, 0, 0, 1);
        idle(2, 0);
        vs_i = 1'b0;
        idle(3, 0);
        vs_pulse();

        // Immediate commit
        do_write(6'd0, 32'h55, 0, 0, 0);
        do_write(6'd10, 32'h2, 0, 0, 0);
        idle(3, 0);

        // Unmapped write, then clear
        do_write(6'd20, 32'hff, 1, 0, 0);
        idle(2, 0);
        do_write(6'd10, 32'h4, 0, 0, 0);
        idle(2, 0);

        // Reset while an address is held
        do_write(6'd10, 32'h1, 0, 0, 0);
        awaddr = 32'h0000_0004; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        @(negedge clk);
        apply_reset();
        idle(2, 0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 19);
            data = $urandom;
            if (r <= 8)       idx = 6'(r);
            else if (r <= 10) idx = 6'd9;
            else if (r <= 16) begin
                idx = 6'd10;
                data[2:0] = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b001;
            end else idx = 6'($urandom_range(11, 63));
            do_write(idx, data, $urandom_range(0, 3), $urandom_range(0, 3),
                     ($urandom_range(0, 9) == 0));
            idle($urandom_range(0, 3), 1);
            if ($urandom_range(0, 99) == 0) apply_reset();
        end
        idle(4, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
